// File: rtl/fft_seq_axil_pkg.sv
// Shared constants and types for the FFT AXI4-Lite register slave.
package fft_seq_axil_pkg;

  localparam int NUM_REGS = 4;

  localparam logic [3:0] REG_CTRL    = 4'h0;
  localparam logic [3:0] REG_CFG     = 4'h4;
  localparam logic [3:0] REG_DIN     = 4'h8;
  localparam logic [3:0] REG_SCRATCH = 4'hC;

  typedef logic [1:0] axil_resp_t;
  localparam axil_resp_t RESP_OKAY = 2'b00;

  // Map a word address (byte address bits [3:2]) to a register index.
  function automatic logic [1:0] reg_index(input logic [1:0] word_addr);
    logic [3:0] w_off;
    w_off = {word_addr, 2'b00};
    case (w_off)
      REG_CTRL:    return 2'd0;
      REG_CFG:     return 2'd1;
      REG_DIN:     return 2'd2;
      REG_SCRATCH: return 2'd3;
      default:     return 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/axil_chan_buf.sv
// One-entry holding register for an AXI channel; ready is a registered "empty".
module axil_chan_buf #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_valid,
  input  logic [W-1:0] i_data,
  input  logic         i_pop,
  output logic         o_ready,
  output logic         o_full,
  output logic [W-1:0] o_data
);

  logic         r_full;
  logic         r_ready;
  logic [W-1:0] r_data;
  logic         w_push;

  assign w_push  = i_valid && r_ready;
  assign o_ready = r_ready;
  assign o_full  = r_full;
  assign o_data  = r_data;

  // Ready stays low through reset and rises on the first edge after release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_full  <= 1'b0;
      r_ready <= 1'b0;
      r_data  <= '0;
    end else begin
      if (w_push) begin
        r_full <= 1'b1;
        r_data <= i_data;
      end else if (i_pop) begin
        r_full <= 1'b0;
      end
      r_ready <= !(w_push || (r_full && !i_pop));
    end
  end

endmodule

// File: rtl/fft_seq_axil_regs.sv
// AXI4-Lite slave holding four 32-bit control registers for the sequential FFT core,
// exporting their contents and a one-cycle update strobe per register.
module fft_seq_axil_regs
  import fft_seq_axil_pkg::*;
#(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 4
) (
  input  logic                                     ACLK,
  input  logic                                     ARESETN,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]            S_AXI_AWADDR,
  input  logic [2:0]                               S_AXI_AWPROT,
  input  logic                                     S_AXI_AWVALID,
  output logic                                     S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]            S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0]          S_AXI_WSTRB,
  input  logic                                     S_AXI_WVALID,
  output logic                                     S_AXI_WREADY,
  output logic [1:0]                               S_AXI_BRESP,
  output logic                                     S_AXI_BVALID,
  input  logic                                     S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]            S_AXI_ARADDR,
  input  logic [2:0]                               S_AXI_ARPROT,
  input  logic                                     S_AXI_ARVALID,
  output logic                                     S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]            S_AXI_RDATA,
  output logic [1:0]                               S_AXI_RRESP,
  output logic                                     S_AXI_RVALID,
  input  logic                                     S_AXI_RREADY,
  output logic [NUM_REGS*C_S_AXI_DATA_WIDTH-1:0]   reg_q,
  output logic [NUM_REGS-1:0]                      wr_pulse
);

  localparam int DW = C_S_AXI_DATA_WIDTH;
  localparam int SW = C_S_AXI_DATA_WIDTH / 8;
  localparam int AW = C_S_AXI_ADDR_WIDTH;

  // A transfer happens on an edge where VALID and READY are both high; once
  // VALID is raised its payload stays put until that edge, and no READY here
  // depends combinationally on any VALID.

  logic              w_aw_full;
  logic [AW-1:0]     w_aw_addr;
  logic              w_w_full;
  logic [DW+SW-1:0]  w_w_data;
  logic              w_commit;
  logic [1:0]        w_wsel;
  logic [1:0]        w_rsel;
  logic              w_ar_hs;
  logic              w_unused;

  logic [DW-1:0]       r_regs [NUM_REGS];
  logic                r_bvalid;
  logic [NUM_REGS-1:0] r_wr_pulse;
  logic                r_rvalid;
  logic                r_arready;
  logic [DW-1:0]       r_rdata;

  axil_chan_buf #(.W(AW)) u_aw_buf (
    .clk     (ACLK),
    .rst_n   (ARESETN),
    .i_valid (S_AXI_AWVALID),
    .i_data  (S_AXI_AWADDR),
    .i_pop   (w_commit),
    .o_ready (S_AXI_AWREADY),
    .o_full  (w_aw_full),
    .o_data  (w_aw_addr)
  );

  axil_chan_buf #(.W(DW+SW)) u_w_buf (
    .clk     (ACLK),
    .rst_n   (ARESETN),
    .i_valid (S_AXI_WVALID),
    .i_data  ({S_AXI_WSTRB, S_AXI_WDATA}),
    .i_pop   (w_commit),
    .o_ready (S_AXI_WREADY),
    .o_full  (w_w_full),
    .o_data  (w_w_data)
  );

  assign w_commit = w_aw_full && w_w_full && !r_bvalid;
  assign w_wsel   = reg_index(w_aw_addr[3:2]);
  assign w_rsel   = reg_index(S_AXI_ARADDR[3:2]);
  assign w_ar_hs  = S_AXI_ARVALID && r_arready;
  assign w_unused = ^{S_AXI_AWPROT, S_AXI_ARPROT, w_aw_addr[1:0], S_AXI_ARADDR[1:0]};

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= '0;
      r_bvalid   <= 1'b0;
      r_wr_pulse <= '0;
    end else begin
      r_wr_pulse <= '0;
      if (w_commit) begin
        for (int b = 0; b < SW; b++) begin
          if (w_w_data[DW+b]) r_regs[w_wsel][8*b +: 8] <= w_w_data[8*b +: 8];
        end
        r_wr_pulse[w_wsel] <= 1'b1;
        r_bvalid           <= 1'b1;
      end else if (r_bvalid && S_AXI_BREADY) begin
        r_bvalid <= 1'b0;
      end
    end
  end

  // A read landing on the same edge as a commit sees the pre-write value.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      r_rvalid  <= 1'b0;
      r_arready <= 1'b0;
      r_rdata   <= '0;
    end else begin
      if (w_ar_hs) begin
        r_rdata  <= r_regs[w_rsel];
        r_rvalid <= 1'b1;
      end else if (r_rvalid && S_AXI_RREADY) begin
        r_rvalid <= 1'b0;
      end
      r_arready <= !(w_ar_hs || (r_rvalid && !S_AXI_RREADY));
    end
  end

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_reg_q
    assign reg_q[g*DW +: DW] = r_regs[g];
  end

  assign S_AXI_BVALID  = r_bvalid;
  assign S_AXI_BRESP   = RESP_OKAY;
  assign S_AXI_RVALID  = r_rvalid;
  assign S_AXI_RRESP   = RESP_OKAY;
  assign S_AXI_RDATA   = r_rdata;
  assign S_AXI_ARREADY = r_arready;
  assign wr_pulse      = r_wr_pulse;

endmodule

// File: tb/tb_fft_seq_axil_regs.sv
// Self-checking bench for fft_seq_axil_regs against a register-array model.
module tb_fft_seq_axil_regs;

  logic         ACLK;
  logic         ARESETN;
  logic [3:0]   S_AXI_AWADDR;
  logic [2:0]   S_AXI_AWPROT;
  logic         S_AXI_AWVALID;
  logic         S_AXI_AWREADY;
  logic [31:0]  S_AXI_WDATA;
  logic [3:0]   S_AXI_WSTRB;
  logic         S_AXI_WVALID;
  logic         S_AXI_WREADY;
  logic [1:0]   S_AXI_BRESP;
  logic         S_AXI_BVALID;
  logic         S_AXI_BREADY;
  logic [3:0]   S_AXI_ARADDR;
  logic [2:0]   S_AXI_ARPROT;
  logic         S_AXI_ARVALID;
  logic         S_AXI_ARREADY;
  logic [31:0]  S_AXI_RDATA;
  logic [1:0]   S_AXI_RRESP;
  logic         S_AXI_RVALID;
  logic         S_AXI_RREADY;
  logic [127:0] reg_q;
  logic [3:0]   wr_pulse;

  int total = 0;
  int bad   = 0;
  logic [31:0] model_regs [4];
  logic [31:0] exp_q [$];

  fft_seq_axil_regs dut (
    .ACLK          (ACLK),
    .ARESETN       (ARESETN),
    .S_AXI_AWADDR  (S_AXI_AWADDR),
    .S_AXI_AWPROT  (S_AXI_AWPROT),
    .S_AXI_AWVALID (S_AXI_AWVALID),
    .S_AXI_AWREADY (S_AXI_AWREADY),
    .S_AXI_WDATA   (S_AXI_WDATA),
    .S_AXI_WSTRB   (S_AXI_WSTRB),
    .S_AXI_WVALID  (S_AXI_WVALID),
    .S_AXI_WREADY  (S_AXI_WREADY),
    .S_AXI_BRESP   (S_AXI_BRESP),
    .S_AXI_BVALID  (S_AXI_BVALID),
    .S_AXI_BREADY  (S_AXI_BREADY),
    .S_AXI_ARADDR  (S_AXI_ARADDR),
    .S_AXI_ARPROT  (S_AXI_ARPROT),
    .S_AXI_ARVALID (S_AXI_ARVALID),
    .S_AXI_ARREADY (S_AXI_ARREADY),
    .S_AXI_RDATA   (S_AXI_RDATA),
    .S_AXI_RRESP   (S_AXI_RRESP),
    .S_AXI_RVALID  (S_AXI_RVALID),
    .S_AXI_RREADY  (S_AXI_RREADY),
    .reg_q         (reg_q),
    .wr_pulse      (wr_pulse)
  );

  // Clock and watchdog
  initial ACLK = 1'b0;
  always #5 ACLK = ~ACLK;

  initial begin
    #1000000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference model: each register is the last write merged through its byte mask.
  function automatic logic [31:0] strb_mask(input logic [3:0] s);
    return {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
  endfunction

  task automatic model_write(input logic [3:0] addr, input logic [31:0] data, input logic [3:0] strb);
    logic [31:0] m;
    m = strb_mask(strb);
    model_regs[addr[3:2]] = (model_regs[addr[3:2]] & ~m) | (data & m);
  endtask

  function automatic logic [127:0] model_flat();
    return {model_regs[3], model_regs[2], model_regs[1], model_regs[0]};
  endfunction

  task automatic tick();
    @(posedge ACLK);
    #1;
  endtask

  // Driver tasks
  task automatic do_write(input logic [3:0] addr, input logic [31:0] data, input logic [3:0] strb,
                          output logic [1:0] resp, output logic [3:0] pulse, output int lat);
    bit aw_done, w_done, aw_hs, w_hs;
    int cyc;
    aw_done = 0; w_done = 0; cyc = 0;
    S_AXI_AWADDR = addr; S_AXI_AWVALID = 1'b1;
    S_AXI_WDATA = data; S_AXI_WSTRB = strb; S_AXI_WVALID = 1'b1;
    S_AXI_BREADY = 1'b1;
    while (!(aw_done && w_done) && cyc < 50) begin
      aw_hs = S_AXI_AWVALID && S_AXI_AWREADY;
      w_hs  = S_AXI_WVALID && S_AXI_WREADY;
      tick();
      cyc++;
      if (aw_hs) begin aw_done = 1; S_AXI_AWVALID = 1'b0; end
      if (w_hs)  begin w_done = 1;  S_AXI_WVALID = 1'b0;  end
    end
    lat = 0;
    while (!S_AXI_BVALID && lat < 50) begin tick(); lat++; end
    resp = S_AXI_BRESP;
    pulse = wr_pulse;
    total++;
    if (!S_AXI_BVALID) begin bad++; $display("FAIL write_timeout addr=%h got no BVALID", addr); end
    tick();
  endtask

  task automatic do_read(input logic [3:0] addr, output logic [31:0] data, output logic [1:0] resp,
                         output int lat);
    bit done, hs;
    int cyc;
    done = 0; cyc = 0;
    S_AXI_ARADDR = addr; S_AXI_ARVALID = 1'b1; S_AXI_RREADY = 1'b1;
    while (!done && cyc < 50) begin
      hs = S_AXI_ARVALID && S_AXI_ARREADY;
      tick();
      cyc++;
      if (hs) begin done = 1; S_AXI_ARVALID = 1'b0; end
    end
    lat = 0;
    while (!S_AXI_RVALID && lat < 50) begin tick(); lat++; end
    data = S_AXI_RDATA;
    resp = S_AXI_RRESP;
    total++;
    if (!S_AXI_RVALID) begin bad++; $display("FAIL read_timeout addr=%h got no RVALID", addr); end
    tick();
  endtask

  // Tests
  task automatic test_reset();
    logic [127:0] obs [8];
    logic [127:0] req [8];
    string nm [8];
    ARESETN = 1'b0;
    S_AXI_AWADDR = '0; S_AXI_AWPROT = '0; S_AXI_AWVALID = 1'b0;
    S_AXI_WDATA = '0; S_AXI_WSTRB = '0; S_AXI_WVALID = 1'b0; S_AXI_BREADY = 1'b0;
    S_AXI_ARADDR = '0; S_AXI_ARPROT = '0; S_AXI_ARVALID = 1'b0; S_AXI_RREADY = 1'b0;
    for (int i = 0; i < 4; i++) model_regs[i] = '0;
    #100;
    obs[0] = 128'(S_AXI_AWREADY); nm[0] = "rst_awready";
    obs[1] = 128'(S_AXI_WREADY);  nm[1] = "rst_wready";
    obs[2] = 128'(S_AXI_ARREADY); nm[2] = "rst_arready";
    obs[3] = 128'(S_AXI_BVALID);  nm[3] = "rst_bvalid";
    obs[4] = 128'(S_AXI_RVALID);  nm[4] = "rst_rvalid";
    obs[5] = 128'(S_AXI_RDATA);   nm[5] = "rst_rdata";
    obs[6] = reg_q;               nm[6] = "rst_reg_q";
    obs[7] = 128'(wr_pulse);      nm[7] = "rst_wr_pulse";
    for (int i = 0; i < 8; i++) begin
      total++;
      if (obs[i] !== 128'd0) begin bad++; $display("FAIL %s got=%0h exp=0", nm[i], obs[i]); end
    end
    #103;
    ARESETN = 1'b1;
    tick();
    obs[0] = 128'(S_AXI_AWREADY); req[0] = 128'd1; nm[0] = "post_awready";
    obs[1] = 128'(S_AXI_WREADY);  req[1] = 128'd1; nm[1] = "post_wready";
    obs[2] = 128'(S_AXI_ARREADY); req[2] = 128'd1; nm[2] = "post_arready";
    obs[3] = 128'(S_AXI_BVALID);  req[3] = 128'd0; nm[3] = "post_bvalid";
    obs[4] = 128'(S_AXI_RVALID);  req[4] = 128'd0; nm[4] = "post_rvalid";
    for (int i = 0; i < 5; i++) begin
      total++;
      if (obs[i] !== req[i]) begin bad++; $display("FAIL %s got=%0h exp=%0h", nm[i], obs[i], req[i]); end
    end
  endtask

  task automatic test_seq_writes();
    logic [1:0] resp;
    logic [3:0] pulse;
    logic [31:0] d;
    logic [3:0] a;
    int lat;
    for (int i = 0; i < 4; i++) begin
      a = 4'(i * 4);
      do_write(a, 32'(i + 1), 4'hF, resp, pulse, lat);
      model_write(a, 32'(i + 1), 4'hF);
      total++; if (resp !== 2'b00) begin bad++; $display("FAIL seq_bresp[%0d] got=%0h exp=0", i, resp); end
      total++; if (pulse !== 4'(1 << i)) begin bad++; $display("FAIL seq_pulse[%0d] got=%b exp=%b", i, pulse, 4'(1 << i)); end
      total++; if (lat !== 1) begin bad++; $display("FAIL seq_wlat[%0d] got=%0d exp=1", i, lat); end
      total++; if (reg_q !== model_flat()) begin bad++; $display("FAIL seq_reg_q[%0d] got=%h exp=%h", i, reg_q, model_flat()); end
    end
    for (int i = 0; i < 4; i++) begin
      do_read(4'(i * 4), d, resp, lat);
      total++; if (d !== model_regs[i]) begin bad++; $display("FAIL seq_rdata[%0d] got=%h exp=%h", i, d, model_regs[i]); end
      total++; if (resp !== 2'b00) begin bad++; $display("FAIL seq_rresp[%0d] got=%0h exp=0", i, resp); end
      total++; if (lat !== 0) begin bad++; $display("FAIL seq_rlat[%0d] got=%0d exp=0", i, lat); end
    end
  endtask

  task automatic test_out_of_order();
    S_AXI_BREADY = 1'b1;
    S_AXI_WDATA = 32'hDEADBEEF; S_AXI_WSTRB = 4'hF; S_AXI_WVALID = 1'b1;
    tick();
    S_AXI_WVALID = 1'b0;
    total++; if (S_AXI_WREADY !== 1'b0) begin bad++; $display("FAIL ooo_wready_drop got=%b exp=0", S_AXI_WREADY); end
    tick(); tick();
    total++; if (S_AXI_WREADY !== 1'b0) begin bad++; $display("FAIL ooo_wready_hold got=%b exp=0", S_AXI_WREADY); end
    total++; if (S_AXI_BVALID !== 1'b0) begin bad++; $display("FAIL ooo_bvalid_early got=%b exp=0", S_AXI_BVALID); end
    S_AXI_AWADDR = 4'h4; S_AXI_AWVALID = 1'b1;
    tick();
    S_AXI_AWVALID = 1'b0;
    total++; if (S_AXI_BVALID !== 1'b0) begin bad++; $display("FAIL ooo_bvalid_hs got=%b exp=0", S_AXI_BVALID); end
    total++; if (reg_q !== model_flat()) begin bad++; $display("FAIL ooo_reg_early got=%h exp=%h", reg_q, model_flat()); end
    tick();
    model_write(4'h4, 32'hDEADBEEF, 4'hF);
    total++; if (S_AXI_BVALID !== 1'b1) begin bad++; $display("FAIL ooo_bvalid got=%b exp=1", S_AXI_BVALID); end
    total++; if (wr_pulse !== 4'b0010) begin bad++; $display("FAIL ooo_pulse got=%b exp=0010", wr_pulse); end
    total++; if (reg_q !== model_flat()) begin bad++; $display("FAIL ooo_reg_q got=%h exp=%h", reg_q, model_flat()); end
    tick();
    total++; if (S_AXI_BVALID !== 1'b0) begin bad++; $display("FAIL ooo_bvalid_clr got=%b exp=0", S_AXI_BVALID); end
    total++; if ({S_AXI_AWREADY, S_AXI_WREADY} !== 2'b11) begin bad++; $display("FAIL ooo_ready_back got=%b exp=11", {S_AXI_AWREADY, S_AXI_WREADY}); end
  endtask

  task automatic test_strobes();
    logic [1:0] resp;
    logic [3:0] pulse;
    logic [31:0] d;
    int lat;
    do_write(4'h8, 32'h00000003, 4'hF, resp, pulse, lat);
    model_write(4'h8, 32'h00000003, 4'hF);
    do_write(4'h8, 32'hAABBCCDD, 4'b0010, resp, pulse, lat);
    model_write(4'h8, 32'hAABBCCDD, 4'b0010);
    total++; if (reg_q[95:64] !== 32'h0000CC03) begin bad++; $display("FAIL strb_reg2 got=%h exp=0000cc03", reg_q[95:64]); end
    do_read(4'h8, d, resp, lat);
    total++; if (d !== model_regs[2]) begin bad++; $display("FAIL strb_rdata got=%h exp=%h", d, model_regs[2]); end
    do_write(4'hC, 32'h55555555, 4'b0000, resp, pulse, lat);
    model_write(4'hC, 32'h55555555, 4'b0000);
    total++; if (pulse !== 4'b1000) begin bad++; $display("FAIL strb0_pulse got=%b exp=1000", pulse); end
    total++; if (resp !== 2'b00) begin bad++; $display("FAIL strb0_bresp got=%0h exp=0", resp); end
    total++; if (reg_q !== model_flat()) begin bad++; $display("FAIL strb0_reg_q got=%h exp=%h", reg_q, model_flat()); end
  endtask

  task automatic test_write_backpressure();
    logic [31:0] old2;
    bit aw_hs, w_hs;
    S_AXI_BREADY = 1'b0;
    S_AXI_AWADDR = 4'hC; S_AXI_AWVALID = 1'b1;
    S_AXI_WDATA = 32'h11112222; S_AXI_WSTRB = 4'hF; S_AXI_WVALID = 1'b1;
    tick();
    S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0;
    tick();
    model_write(4'hC, 32'h11112222, 4'hF);
    total++; if (S_AXI_BVALID !== 1'b1) begin bad++; $display("FAIL bp_first_bvalid got=%b exp=1", S_AXI_BVALID); end
    old2 = model_regs[2];
    S_AXI_AWADDR = 4'h8; S_AXI_AWVALID = 1'b1;
    S_AXI_WDATA = 32'h33334444; S_AXI_WVALID = 1'b1;
    for (int c = 0; c < 5; c++) begin
      aw_hs = S_AXI_AWVALID && S_AXI_AWREADY;
      w_hs  = S_AXI_WVALID && S_AXI_WREADY;
      tick();
      if (aw_hs) S_AXI_AWVALID = 1'b0;
      if (w_hs)  S_AXI_WVALID = 1'b0;
      total++; if (S_AXI_BVALID !== 1'b1) begin bad++; $display("FAIL bp_bvalid_hold[%0d] got=%b exp=1", c, S_AXI_BVALID); end
      total++; if ({S_AXI_AWREADY, S_AXI_WREADY} !== 2'b00) begin bad++; $display("FAIL bp_ready_low[%0d] got=%b exp=00", c, {S_AXI_AWREADY, S_AXI_WREADY}); end
      total++; if (reg_q[95:64] !== old2) begin bad++; $display("FAIL bp_no_commit[%0d] got=%h exp=%h", c, reg_q[95:64], old2); end
    end
    S_AXI_BREADY = 1'b1;
    tick();
    total++; if (S_AXI_BVALID !== 1'b0) begin bad++; $display("FAIL bp_bvalid_clr got=%b exp=0", S_AXI_BVALID); end
    total++; if (reg_q[95:64] !== old2) begin bad++; $display("FAIL bp_still_old got=%h exp=%h", reg_q[95:64], old2); end
    tick();
    model_write(4'h8, 32'h33334444, 4'hF);
    total++; if (S_AXI_BVALID !== 1'b1) begin bad++; $display("FAIL bp_second_bvalid got=%b exp=1", S_AXI_BVALID); end
    total++; if (wr_pulse !== 4'b0100) begin bad++; $display("FAIL bp_second_pulse got=%b exp=0100", wr_pulse); end
    total++; if (reg_q !== model_flat()) begin bad++; $display("FAIL bp_second_reg got=%h exp=%h", reg_q, model_flat()); end
    tick();
  endtask

  task automatic test_read_backpressure();
    S_AXI_RREADY = 1'b0;
    S_AXI_ARADDR = 4'h8; S_AXI_ARVALID = 1'b1;
    tick();
    S_AXI_ARADDR = 4'h0;
    total++; if (S_AXI_RVALID !== 1'b1) begin bad++; $display("FAIL rbp_rvalid got=%b exp=1", S_AXI_RVALID); end
    for (int c = 0; c < 5; c++) begin
      tick();
      total++; if (S_AXI_RVALID !== 1'b1) begin bad++; $display("FAIL rbp_rvalid_hold[%0d] got=%b exp=1", c, S_AXI_RVALID); end
      total++; if (S_AXI_RDATA !== model_regs[2]) begin bad++; $display("FAIL rbp_rdata_hold[%0d] got=%h exp=%h", c, S_AXI_RDATA, model_regs[2]); end
      total++; if (S_AXI_ARREADY !== 1'b0) begin bad++; $display("FAIL rbp_arready[%0d] got=%b exp=0", c, S_AXI_ARREADY); end
    end
    S_AXI_RREADY = 1'b1;
    tick();
    total++; if (S_AXI_RVALID !== 1'b0) begin bad++; $display("FAIL rbp_rvalid_clr got=%b exp=0", S_AXI_RVALID); end
    tick();
    S_AXI_ARVALID = 1'b0;
    total++; if (S_AXI_RDATA !== model_regs[0] || S_AXI_RVALID !== 1'b1) begin bad++; $display("FAIL rbp_second got=%h/%b exp=%h/1", S_AXI_RDATA, S_AXI_RVALID, model_regs[0]); end
    tick();
  endtask

  task automatic test_read_write_same_edge();
    logic [31:0] old1, d;
    logic [1:0] resp;
    int lat;
    old1 = model_regs[1];
    S_AXI_BREADY = 1'b1; S_AXI_RREADY = 1'b1;
    S_AXI_AWADDR = 4'h4; S_AXI_AWVALID = 1'b1;
    S_AXI_WDATA = 32'h0BADF00D; S_AXI_WSTRB = 4'hF; S_AXI_WVALID = 1'b1;
    tick();
    S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0;
    S_AXI_ARADDR = 4'h4; S_AXI_ARVALID = 1'b1;
    tick();
    S_AXI_ARVALID = 1'b0;
    model_write(4'h4, 32'h0BADF00D, 4'hF);
    total++; if (S_AXI_RDATA !== old1) begin bad++; $display("FAIL same_edge_rdata got=%h exp=%h", S_AXI_RDATA, old1); end
    total++; if (S_AXI_BVALID !== 1'b1 || reg_q !== model_flat()) begin bad++; $display("FAIL same_edge_commit got=%b/%h exp=1/%h", S_AXI_BVALID, reg_q, model_flat()); end
    tick();
    do_read(4'h4, d, resp, lat);
    total++; if (d !== model_regs[1]) begin bad++; $display("FAIL same_edge_after got=%h exp=%h", d, model_regs[1]); end
  endtask

  task automatic test_random();
    logic [3:0] a, s;
    logic [31:0] d, e;
    logic [1:0] resp;
    logic [3:0] pulse;
    int lat;
    for (int n = 0; n < 40; n++) begin
      a = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 1) == 1) begin
        d = $urandom;
        s = 4'($urandom_range(0, 15));
        do_write(a, d, s, resp, pulse, lat);
        model_write(a, d, s);
        total++; if (pulse !== 4'(1 << a[3:2]) || resp !== 2'b00) begin bad++; $display("FAIL rnd_wr[%0d] got=%b/%0h exp=%b/0", n, pulse, resp, 4'(1 << a[3:2])); end
        total++; if (reg_q !== model_flat()) begin bad++; $display("FAIL rnd_reg_q[%0d] got=%h exp=%h", n, reg_q, model_flat()); end
      end else begin
        exp_q.push_back(model_regs[a[3:2]]);
        do_read(a, d, resp, lat);
        e = exp_q.pop_front();
        total++; if (d !== e || resp !== 2'b00) begin bad++; $display("FAIL rnd_rd[%0d] got=%h/%0h exp=%h/0", n, d, resp, e); end
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [1:0] resp;
    logic [3:0] pulse;
    logic [31:0] d;
    int lat;
    S_AXI_BREADY = 1'b0; S_AXI_RREADY = 1'b0;
    S_AXI_AWADDR = 4'h0; S_AXI_AWVALID = 1'b1;
    S_AXI_WDATA = 32'h00000077; S_AXI_WSTRB = 4'hF; S_AXI_WVALID = 1'b1;
    S_AXI_ARADDR = 4'h4; S_AXI_ARVALID = 1'b1;
    tick();
    S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0; S_AXI_ARVALID = 1'b0;
    tick();
    total++; if ({S_AXI_BVALID, S_AXI_RVALID} !== 2'b11) begin bad++; $display("FAIL mid_pending got=%b exp=11", {S_AXI_BVALID, S_AXI_RVALID}); end
    #2 ARESETN = 1'b0;
    #1;
    for (int i = 0; i < 4; i++) model_regs[i] = '0;
    total++; if ({S_AXI_BVALID, S_AXI_RVALID} !== 2'b00) begin bad++; $display("FAIL mid_valids got=%b exp=00", {S_AXI_BVALID, S_AXI_RVALID}); end
    total++; if (reg_q !== model_flat() || wr_pulse !== 4'b0000) begin bad++; $display("FAIL mid_reg_q got=%h/%b exp=0/0", reg_q, wr_pulse); end
    tick(); tick();
    #2 ARESETN = 1'b1;
    S_AXI_BREADY = 1'b1; S_AXI_RREADY = 1'b1;
    tick();
    do_write(4'hC, 32'hCAFEF00D, 4'hF, resp, pulse, lat);
    model_write(4'hC, 32'hCAFEF00D, 4'hF);
    total++; if (pulse !== 4'b1000 || resp !== 2'b00 || lat !== 1) begin bad++; $display("FAIL mid_write got=%b/%0h/%0d exp=1000/0/1", pulse, resp, lat); end
    total++; if (reg_q !== model_flat()) begin bad++; $display("FAIL mid_write_reg got=%h exp=%h", reg_q, model_flat()); end
    do_read(4'hC, d, resp, lat);
    total++; if (d !== model_regs[3]) begin bad++; $display("FAIL mid_read got=%h exp=%h", d, model_regs[3]); end
  endtask

  initial begin
    test_reset();
    test_seq_writes();
    test_out_of_order();
    test_strobes();
    test_write_backpressure();
    test_read_backpressure();
    test_read_write_same_edge();
    test_random();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fft_seq_axil_regs.md
# fft_seq_axil_regs

AXI4-Lite slave register file that answers the S00_AXI transactions issued by the master VIP in the FFT block design. It holds four 32-bit software-visible registers at word offsets 0x0–0xC, accepts single-beat writes with byte strobes, and returns single-beat reads. It exports every register value and a one-cycle write strobe per register to the sequential FFT datapath.

## Interface
- C_S_AXI_DATA_WIDTH, 32, data bus width; only 32 is supported.
- C_S_AXI_ADDR_WIDTH, 4, byte-address width; bits [1:0] are ignored, bits [3:2] select the register.
- ACLK  in  1  single clock; all logic on the rising edge.
- ARESETN  in  1  reset; asynchronous assert, active-low.
- S_AXI_AWADDR  in  4  write address. S_AXI_AWPROT  in  3  ignored. S_AXI_AWVALID  in  1. S_AXI_AWREADY  out  1.
- S_AXI_WDATA  in  32. S_AXI_WSTRB  in  4  byte enables. S_AXI_WVALID  in  1. S_AXI_WREADY  out  1.
- S_AXI_BRESP  out  2  always 2'b00 (OKAY). S_AXI_BVALID  out  1. S_AXI_BREADY  in  1.
- S_AXI_ARADDR  in  4. S_AXI_ARPROT  in  3  ignored. S_AXI_ARVALID  in  1. S_AXI_ARREADY  out  1.
- S_AXI_RDATA  out  32. S_AXI_RRESP  out  2  always 2'b00. S_AXI_RVALID  out  1. S_AXI_RREADY  in  1.
- reg_q  out  128  register contents; reg n is bits [32n+31:32n].
- wr_pulse  out  4  one-hot, high for one cycle on the edge register n is updated.

## Operation
- Reset (ARESETN low, asynchronous): all registers 0, reg_q 0, wr_pulse 0, BVALID 0, RVALID 0, RDATA 0, both write buffers empty.
- Write channel, two independent one-entry buffers (AW and W):
  - AWREADY = AW buffer empty. WREADY = W buffer empty. Both are registered outputs.
  - AW and W are accepted in either order, or together; each is latched on its handshake edge.
  - Commit condition: both buffers full and BVALID low. On the next edge:
    - the selected register is updated byte-wise per WSTRB;
    - wr_pulse[n] rises;
    - BVALID rises;
    - both buffers are emptied.
  - BVALID is held until BREADY. While BVALID and !BREADY, no commit occurs; full buffers keep their READY low.
  - WSTRB = 0: the register is unchanged, but wr_pulse and B are still produced.
- Read channel:
  - ARREADY = !RVALID.
  - On the AR handshake edge, RDATA is loaded from register ARADDR[3:2] and RVALID rises.
  - RDATA is held stable until the RVALID && RREADY edge, which clears RVALID.
- Simultaneous read and write commit to the same register on one edge: RDATA gets the pre-write value.
- Registers are plain read/write; the read value always equals the last write, masked by its strobes.

## Timing
- Write latency: AW and W handshakes on edge N give a register update, wr_pulse and BVALID on edge N+1. If W arrives k cycles after AW, the commit is one edge after the W handshake.
- Maximum write rate: one write per two cycles with BREADY held high.
- Read latency: AR handshake on edge N gives RVALID on edge N. Maximum read rate is one read per two cycles with RREADY high.
- The read and write paths are fully independent; neither stalls the other.
- No combinational path from any input to any output, except from reg_q to the FFT core (registered).

## Structure
- Package fft_seq_axil_pkg holds:
  - NUM_REGS = 4;
  - register offset localparams REG_CTRL=0x0, REG_CFG=0x4, REG_DIN=0x8, REG_SCRATCH=0xC;
  - RESP_OKAY = 2'b00;
  - typedef axil_resp_t.
- One sub-module is natural: axil_chan_buf, a one-entry valid/ready holding register parameterised by width, instantiated for AW (4 bits) and W (36 bits). Everything else stays flat.

## Test plan
- Reset: hold ARESETN low for 200 ns.
  - During reset: all outputs 0.
  - After release: AWREADY=WREADY=ARREADY=1, BVALID=RVALID=0.
- Sequential writes and readback:
  - Write 0x1, 0x2, 0x3, 0x4 to 0x0, 0x4, 0x8, 0xC, then read back.
  - Required: each BRESP=0; wr_pulse = 0001, 0010, 0100, 1000 in turn; reads return 0x1..0x4 with RRESP=0.
- Out-of-order channels:
  - Present W (0xDEADBEEF) 3 cycles before AW (0x4).
  - Required: WREADY drops after the W handshake; the register updates and BVALID rises one edge after the AW handshake.
- Byte strobes:
  - Reg 2 holds 0x00000003; write 0xAABBCCDD with WSTRB=4'b0010.
  - Required: reg 2 reads 0x0000CC03.
- Back-pressure:
  - Hold BREADY low for 5 cycles while a second AW+W is offered. Required: BVALID stays high, AWREADY=WREADY=0, and the second write does not commit until BREADY.
  - Hold RREADY low for 5 cycles. Required: RDATA stays stable and ARREADY=0.
- Reset mid-operation:
  - Assert ARESETN while BVALID and RVALID are pending.
  - Required: both drop in the same cycle, reg_q=0, and the next write completes normally.
